// File: rtl/led7_pkg.sv
// Shared types and constants for the scanned seven-segment driver.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package led7_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/led7_scan_driver_if.sv
// Display bus between the datapath (master) and the scan driver (slave).
// The master presents shadow data plus load and observes the pins.
interface led7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic                    lz_blank;
    logic                    load;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    modport master (
        output value_in, dp_in, digit_en,
        output blink_en, lz_blank, load,
        input  seg, dig_sel, frame_done
    );

    modport slave (
        input  value_in, dp_in, digit_en,
        input  blink_en, lz_blank, load,
        output seg, dig_sel, frame_done
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment decoder with dp, blanking and
// output polarity; output byte is {dp,g,f,e,d,c,b,a}.
module seg7_decode
    import led7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  nibble_t    nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] raw;

    always_comb begin
        raw = blank ? SEG_OFF : {dp, SEG_CODE[nib]};
        seg = ACTIVE_LOW ? ~raw : raw;
    end

endmodule

// File: rtl/led7_scan_driver.sv
// Time-multiplexed seven-segment driver: shadow registers, prescaler,
// scan index, blink timing and leading-zero suppression.
module led7_scan_driver
    import led7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input logic          clock,
    input logic          reset,
    led7_scan_driver_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [7:0] SEG_IDLE =
        SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE =
        DIG_ACTIVE_LOW ? '1 : '0;

    nibble_t [NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]    dp_q;
    logic [NUM_DIGITS-1:0]    en_q;
    logic [NUM_DIGITS-1:0]    blk_q;
    logic                     lz_q;

    logic [PW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic [BW-1:0] bcnt_q;
    logic          phase_q;

    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic                  fd_q;

    logic                  tick;
    logic                  wrap;
    logic [IW-1:0]         idx_nxt;
    logic [NUM_DIGITS-1:0] hi_zero;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  acc;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] dig_d;
    logic [7:0]            seg_d;

    assign tick    = (pre_q == PW'(SCAN_DIV - 1));
    assign wrap    = (idx_q == IW'(NUM_DIGITS - 1));
    assign idx_nxt = wrap ? '0 : idx_q + 1'b1;

    // hi_zero[i]: nibbles i..top are all zero
    always_comb begin
        acc       = 1'b1;
        hi_zero   = '0;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc        = acc & (val_q[i] == '0);
            hi_zero[i] = acc;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_vec[i] = ~en_q[i]
                         | (blk_q[i] & phase_q)
                         | (lz_q & hi_zero[i] & (i != 0));
        end
    end

    always_comb begin
        onehot          = '0;
        onehot[idx_nxt] = 1'b1;
        dig_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
    end

    seg7_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec (
        .nib   (val_q[idx_nxt]),
        .dp    (dp_q[idx_nxt]),
        .blank (blank_vec[idx_nxt]),
        .seg   (seg_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            val_q   <= '0;
            dp_q    <= '0;
            en_q    <= '1;
            blk_q   <= '0;
            lz_q    <= 1'b0;
            pre_q   <= '0;
            idx_q   <= IW'(NUM_DIGITS - 1);
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_IDLE;
            dig_q   <= DIG_IDLE;
            fd_q    <= 1'b0;
        end else begin
            if (bus.load) begin
                val_q <= bus.value_in;
                dp_q  <= bus.dp_in;
                en_q  <= bus.digit_en;
                blk_q <= bus.blink_en;
                lz_q  <= bus.lz_blank;
            end
            fd_q <= 1'b0;
            if (tick) begin
                pre_q <= '0;
                idx_q <= idx_nxt;
                seg_q <= seg_d;
                dig_q <= dig_d;
                fd_q  <= wrap;
                if (wrap) begin
                    if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                        bcnt_q  <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_led7_scan_driver.sv
// Directed bench for led7_scan_driver with a per-cycle scoreboard;
// an active-high and an active-low instance see identical stimulus.
module tb_led7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic [7:0]    seg;
        logic [ND-1:0] dig;
        logic          fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld  = 1'b0;

    always #5 clk = ~clk;

    led7_scan_driver_if #(.NUM_DIGITS(ND)) bus_h ();
    led7_scan_driver_if #(.NUM_DIGITS(ND)) bus_l ();

    led7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_h (
        .clock (clk),
        .reset (rst),
        .bus   (bus_h)
    );

    led7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_l (
        .clock (clk),
        .reset (rst),
        .bus   (bus_l)
    );

    logic [6:0] code [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [4*ND-1:0] in_val;
    logic [ND-1:0]   in_dp, in_en, in_bl;
    logic            in_lz;

    logic [4*ND-1:0] m_val;
    logic [ND-1:0]   m_dp, m_en, m_bl;
    logic            m_lz;

    int   cyc = 0;
    int   applied = 0;
    int   miscompares = 0;
    exp_t last;
    exp_t sb [$];

    task automatic set_in(input logic [4*ND-1:0] v,
                          input logic [ND-1:0] dp,
                          input logic [ND-1:0] en,
                          input logic [ND-1:0] bl,
                          input logic lz);
        in_val = v; in_dp = dp; in_en = en; in_bl = bl; in_lz = lz;
        bus_h.value_in = v;  bus_l.value_in = v;
        bus_h.dp_in = dp;    bus_l.dp_in = dp;
        bus_h.digit_en = en; bus_l.digit_en = en;
        bus_h.blink_en = bl; bus_l.blink_en = bl;
        bus_h.lz_blank = lz; bus_l.lz_blank = lz;
    endtask

    task automatic model_reset();
        m_val = '0; m_dp = '0; m_en = '1; m_bl = '0; m_lz = 1'b0;
    endtask

    function automatic logic [7:0] model_seg(int d, bit ph);
        bit blank;
        logic [3:0] n;
        n = m_val[4*d +: 4];
        blank = !m_en[d] || (m_bl[d] && ph)
             || (m_lz && d != 0 && (m_val >> (4*d)) == 0);
        return blank ? 8'h00 : {m_dp[d], code[n]};
    endfunction

    task automatic check(input exp_t e);
        applied++;
        assert (bus_h.seg === e.seg) else begin
            miscompares++;
            $error("FAIL seg_h cyc=%0d got %h exp %h",
                   cyc, bus_h.seg, e.seg);
        end
        applied++;
        assert (bus_h.dig_sel === e.dig) else begin
            miscompares++;
            $error("FAIL dig_h cyc=%0d got %b exp %b",
                   cyc, bus_h.dig_sel, e.dig);
        end
        applied++;
        assert (bus_h.frame_done === e.fd) else begin
            miscompares++;
            $error("FAIL fd_h cyc=%0d got %b exp %b",
                   cyc, bus_h.frame_done, e.fd);
        end
        applied++;
        assert (bus_l.seg === ~e.seg) else begin
            miscompares++;
            $error("FAIL seg_l cyc=%0d got %h exp %h",
                   cyc, bus_l.seg, ~e.seg);
        end
        applied++;
        assert (bus_l.dig_sel === ~e.dig) else begin
            miscompares++;
            $error("FAIL dig_l cyc=%0d got %b exp %b",
                   cyc, bus_l.dig_sel, ~e.dig);
        end
        applied++;
        assert (bus_l.frame_done === e.fd) else begin
            miscompares++;
            $error("FAIL fd_l cyc=%0d got %b exp %b",
                   cyc, bus_l.frame_done, e.fd);
        end
    endtask

    // One clock: predict this edge, push, clock, pop and compare.
    task automatic cyc_step();
        exp_t e;
        int nc, s, d, wb;
        bit ph;
        nc = cyc + 1;
        if (rst) begin
            e = '0;
        end else if (nc % SD == 0) begin
            s  = nc / SD - 1;
            d  = s % ND;
            wb = (s + ND - 1) / ND;
            ph = ((wb / BF) % 2) == 1;
            e.seg = model_seg(d, ph);
            e.dig = ND'(1) << d;
            e.fd  = (d == 0);
        end else begin
            e = last;
            e.fd = 1'b0;
        end
        if (ld && !rst) begin
            m_val = in_val; m_dp = in_dp; m_en = in_en;
            m_bl = in_bl;   m_lz = in_lz;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            cyc = 0;
            model_reset();
        end else begin
            cyc = nc;
        end
        last = e;
        check(sb.pop_front());
    endtask

    task automatic do_load(input logic [4*ND-1:0] v,
                           input logic [ND-1:0] dp,
                           input logic [ND-1:0] en,
                           input logic [ND-1:0] bl,
                           input logic lz);
        set_in(v, dp, en, bl, lz);
        ld = 1'b1; bus_h.load = 1'b1; bus_l.load = 1'b1;
        cyc_step();
        ld = 1'b0; bus_h.load = 1'b0; bus_l.load = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        last = '0;
        set_in('0, '0, '1, '0, 1'b0);
        bus_h.load = 1'b0;
        bus_l.load = 1'b0;

        rst = 1'b1;
        repeat (3) cyc_step();
        rst = 1'b0;
        repeat (10) cyc_step();

        do_load(16'h12AF, 4'b0100, 4'hF, 4'h0, 1'b0);
        repeat (20) cyc_step();

        do_load(16'h0005, 4'h0, 4'hF, 4'h0, 1'b1);
        repeat (20) cyc_step();
        do_load(16'h0000, 4'h0, 4'hF, 4'h0, 1'b1);
        repeat (20) cyc_step();

        do_load(16'h0008, 4'h0, 4'hF, 4'b0010, 1'b0);
        repeat (ND * SD * 5) cyc_step();

        guard = 0;
        while ((cyc + 1) % SD != 0 && guard < 100) begin
            cyc_step();
            guard++;
        end
        do_load(16'h1111, 4'h0, 4'hF, 4'h0, 1'b0);
        repeat (8) cyc_step();

        guard = 0;
        while (((cyc / SD - 1) % ND != 2 || cyc % SD != 1)
               && guard < 100) begin
            cyc_step();
            guard++;
        end
        applied++;
        assert (guard < 100) else begin
            miscompares++;
            $error("FAIL slot2_wait got %0d exp <100", guard);
        end
        rst = 1'b1;
        repeat (2) cyc_step();
        rst = 1'b0;
        repeat (12) cyc_step();

        do_load(16'h0008, 4'h0, 4'b0001, 4'h0, 1'b0);
        repeat (20) cyc_step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule

// File: doc/led7_scan_driver.md
# led7_scan_driver

Parametrised, time-multiplexed seven-segment display driver. It replaces one static decoder per digit with a single shared decoder scanned across NUM_DIGITS digits. It adds a load-strobed shadow register, per-digit blanking and blinking, leading-zero suppression, and selectable output polarity. It sits between the datapath's display values and the board's shared segment and digit-select pins.

## Interface
Parameters:
- NUM_DIGITS, 8: digits scanned; legal range 2..16.
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥2.
- BLINK_FRAMES, 64: full frames per blink half-period; must be ≥1.
- SEG_ACTIVE_LOW, 0: 1 means a segment is lit when its bit is 0.
- DIG_ACTIVE_LOW, 0: 1 means a digit is selected when its bit is 0.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- value_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- digit_en  in  NUM_DIGITS  1 shows the digit; 0 blanks it.
- blink_en  in  NUM_DIGITS  1 makes the digit blink.
- lz_blank  in  1  enables leading-zero suppression.
- load  in  1  single-cycle strobe that captures all the inputs above into the shadow registers.
- seg  out  8  {dp,g,f,e,d,c,b,a}; polarity is set by SEG_ACTIVE_LOW.
- dig_sel  out  NUM_DIGITS  one-hot digit select; polarity is set by DIG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse each time a scan wraps to digit 0.

## Operation
- Shadow registers hold the value, dp, digit_en, blink_en and lz_blank shadows. When load=1 they capture the inputs on that edge. Only the shadow contents are ever displayed.
- Reset values:
  - value shadow 0, dp shadow 0, digit_en shadow all ones, blink_en shadow 0, lz shadow 0.
  - Prescaler 0, index NUM_DIGITS-1, blink counter 0, blink_phase 0.
  - seg is all-inactive: 8'h00, or 8'hFF when SEG_ACTIVE_LOW=1.
  - dig_sel is all-inactive.
  - frame_done is 0.
- Prescaler: counts 0..SCAN_DIV-1 and asserts an internal tick when the count is SCAN_DIV-1. Width is $clog2(SCAN_DIV).
- On each tick:
  - The index advances modulo NUM_DIGITS.
  - seg and dig_sel are registered from the new index.
  - On the wrap NUM_DIGITS-1→0, frame_done pulses and the blink counter increments. This includes the first tick after reset.
- When the blink counter reaches BLINK_FRAMES-1, it returns to 0 and blink_phase toggles.
- Digit i is blank when any one of these holds:
  - its digit_en shadow bit is 0;
  - its blink_en shadow bit is 1 and blink_phase=1;
  - lz shadow=1, i≠0, and nibbles i..NUM_DIGITS-1 are all 0.
- A blank digit drives every segment inactive, including dp. dig_sel stays asserted for the slot so the duty cycle stays constant.
- Decode, written as active-high codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Bit 7 = dp shadow bit. The whole byte is inverted when SEG_ACTIVE_LOW=1.

## Timing
- Latency: one cycle from tick to the outputs.
- seg and dig_sel change together on the same edge, and only on tick edges or reset.
- The outputs stay all-inactive for the first SCAN_DIV cycles after reset.
- Load coincident with a tick: the output registered on that edge uses the old shadow. The new data appears from the next tick.
- Loads between ticks do not disturb the current slot.
- Reset mid-frame: outputs go inactive on the next edge, and the scan restarts exactly as after power-up.
- frame_done is high for exactly one cycle per NUM_DIGITS*SCAN_DIV cycles.

## Structure
- Package led7_pkg holds:
  - the 16-entry active-high segment code constant;
  - the segment-off constant;
  - the nibble typedef.
- Sub-module seg7_decode: a combinational nibble+dp+blank decoder with a polarity parameter. It is instantiated once.
- Prescaler, scan index, blink counter and the leading-zero mask stay in the top module.

## Test plan
Bench configuration: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, active-high unless stated.
- **Reset and first frame:** assert reset for 3 cycles, then release. seg=8'h00 and dig_sel=4'b0000 for 4 cycles. Then dig_sel=4'b0001, and frame_done pulses once in that same cycle.
- **Basic decode:** load value 16'h12AF, dp=4'b0100. The slots show digit0 8'h71, digit1 8'h77, digit2 8'hDB, digit3 8'h06, and dig_sel walks 0001→0010→0100→1000→0001.
- **Leading-zero suppression:** load lz_blank=1 with value 16'h0005. Digits 3, 2 and 1 give 8'h00 and digit0 gives 8'h6D. Loading value 16'h0000 gives digit0 8'h3F and the other digits 8'h00.
- **Blink:** load blink_en=4'b0010 with value 16'h0008. Digit1 shows 8'h3F for 2 frames, then 8'h00 for 2 frames, repeating. The other digits are unaffected.
- **Coincident load and reset mid-frame:**
  - Load 16'h1111 on the same edge as a tick. That slot still shows the old value, and the next slot shows 8'h06.
  - Reset during slot 2. The outputs are inactive on the next edge and the restart timing matches the first scenario.
- **Polarity:** SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value 8 on digit0. seg=8'h80, dig_sel=4'b1110, and the off level is 8'hFF / 4'b1111.
